gf180mcu_osu_sc_12t_tinv_bus_seq: RTL

//   Enable sequencer placed directly upstream of a row of tinv cells that share one tri-state bus net.
//   It arbitrates N requesters round-robin and drives each tinv's EN/EN_BAR pair as registered complements.

---
 rtl/gf180mcu_osu_sc_12t_tinv_bus_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/gf180mcu_osu_sc_12t_tinv_bus_seq.sv
// gf180mcu_osu_sc_12t_tinv_bus_seq
//   Enable sequencer for a row of tinv cells sharing one tri-state bus net.
//   N requesters are arbitrated round-robin. The winner waits through a
//   break-before-make dead time before its EN/EN_BAR pair is asserted, so two
//   drivers can never fight on the net.
//
//   Optional feature macro: TINV_BUS_KEEPER_EN
//     defined   -> KEEP is a registered "nobody drives" flag for a bus keeper
//     undefined -> KEEP is tied low and no keeper logic exists
//
// Ports
//   CLK     in   rising-edge clock
//   RST     in   synchronous reset, active-high
//   REQ     in   [N-1:0]  per-driver request level, held for the whole transfer
//   EN      out  [N-1:0]  tinv enables, at most one bit high
//   EN_BAR  out  [N-1:0]  complement of EN, registered alongside it
//   OWNER   out  [OW-1:0] index of the granted / pending driver
//   BUSY    out  high while in DEAD or DRIVE
//   KEEP    out  bus-keeper enable
//
// Handshake: REQ[i] is a level. Raising it asks for the bus; the bus is held
// until the requester lowers REQ[i]. A low REQ[OWNER] sampled on any edge in
// DEAD or DRIVE releases ownership on that edge; there is no preemption.
//
// All outputs come straight from flops. EN is loaded from the next-state
// decode, so it rises one edge after the FSM enters DRIVE and falls on the
// same edge the release is sampled.

module gf180mcu_osu_sc_12t_tinv_bus_seq #(
    parameter int N           = 4,
    parameter int DEAD_CYCLES = 2,
    localparam int OW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  REQ,
    output logic [N-1:0]  EN,
    output logic [N-1:0]  EN_BAR,
    output logic [OW-1:0] OWNER,
    output logic          BUSY,
    output logic          KEEP
);

    localparam int CW = (DEAD_CYCLES > 0) ? (($clog2(DEAD_CYCLES + 1) > 1) ? $clog2(DEAD_CYCLES + 1) : 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [OW-1:0]  rr_q, rr_d;
    logic [OW-1:0]  owner_d;
    logic [N-1:0]   en_d;
    logic           win_found;
    logic [OW-1:0]  win_idx;
    logic [OW-1:0]  cand;

    // Modulo-N increment; N need not be a power of two.
    function automatic logic [OW-1:0] inc_mod(input logic [OW-1:0] v);
        if (int'(v) == N - 1) return '0;
        return v + 1'b1;
    endfunction

    // Round-robin search starting at rr_q. Scanning offsets from the far end
    // down lets the smallest offset overwrite the result, so it wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = OW'((int'(rr_q) + i) % N);
            if (REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        owner_d = OWNER;
        en_d    = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    if (DEAD_CYCLES > 0) begin
                        cnt_d   = CNT_INIT;
                        state_d = DEAD;
                    end else begin
                        state_d = DRIVE;
                    end
                end
            end
            DEAD: begin
                if (!REQ[OWNER]) begin
                    // Abort: requester gave up before it ever drove.
                    state_d = IDLE;
                    rr_d    = inc_mod(OWNER);
                end else if (cnt_q == '0) begin
                    state_d = DRIVE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRIVE: begin
                if (!REQ[OWNER]) begin
                    state_d = IDLE;
                    rr_d    = inc_mod(OWNER);
                end else begin
                    en_d[OWNER] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            OWNER   <= '0;
            EN      <= '0;
            EN_BAR  <= '1;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            OWNER   <= owner_d;
            EN      <= en_d;
            EN_BAR  <= ~en_d;
            BUSY    <= (state_d != IDLE);
        end
    end

`ifdef TINV_BUS_KEEPER_EN
    // Loaded from the same decode as EN so the keeper hands over on the
    // exact edge a driver turns on or off.
    always_ff @(posedge CLK) begin
        if (RST) KEEP <= 1'b1;
        else     KEEP <= (en_d == '0);
    end
`else
    assign KEEP = 1'b0;
`endif

endmodule
